// File: rtl/signature_dumper_pkg.sv
// Shared types for the end-of-test signature dumper: FSM state encoding,
// halt-detection mode encodings and a small state decode helper.
package signature_dumper_pkg;

   // Dumper FSM states.
   typedef enum logic [2:0] {
      ST_WATCH   = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_e;

   // HALT_MODE encodings.
   localparam int HALT_MODE_ADDR   = 0;  // PC equals HALT_ADDR (after arming)
   localparam int HALT_MODE_STABLE = 1;  // PC unchanged for STABLE_CYCLES samples
   localparam int HALT_MODE_EITHER = 2;  // whichever fires first

   // The core stays frozen from the first read until reset; a timeout releases it.
   function automatic logic holds_core(input state_e s);
      return (s == ST_READ) || (s == ST_WAIT) || (s == ST_SEND) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/signature_dumper_if.sv
// Signature stream port.
// Handshake: a word transfers on every rising clock edge where sig_valid and
// sig_ready are both high. Once sig_valid is raised, sig_valid, sig_data and
// sig_last stay stable until that transfer; sig_ready may change freely and
// has no combinational dependency on sig_valid. sig_last marks the final word.
interface signature_dumper_if #(
   parameter int XLEN = 32
) ();
   logic            sig_valid;
   logic            sig_ready;
   logic [XLEN-1:0] sig_data;
   logic            sig_last;

   modport master (output sig_valid, output sig_data, output sig_last, input sig_ready);
   modport slave  (input sig_valid, input sig_data, input sig_last, output sig_ready);
endinterface

// File: rtl/signature_dumper_halt_detector.sv
// Halt-loop detector: watches the fetch PC and flags the cycle in which the
// core is judged to have reached its terminal loop, either by matching a known
// halt address (only after the PC has left that address once) or by the PC
// sitting still for STABLE_CYCLES consecutive samples.
module signature_dumper_halt_detector
   import signature_dumper_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] HALT_ADDR     = '0,
   parameter int              HALT_MODE     = HALT_MODE_EITHER,
   parameter int              STABLE_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_i,
   output logic            halt_o
);

   localparam int             CW         = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]  STABLE_HIT = CW'(STABLE_CYCLES - 1);

   logic            armed_q, armed_d;
   logic [XLEN-1:0] prev_pc_q, prev_pc_d;
   logic [CW-1:0]   stable_q, stable_d;
   logic            pc_same;
   logic            addr_halt;
   logic            stable_halt;

   // Arming, previous-PC tracking, saturating stable counter and halt decision.
   always_comb begin
      armed_d     = armed_q | (pc_i != HALT_ADDR);
      prev_pc_d   = pc_i;
      pc_same     = (pc_i == prev_pc_q);
      stable_d    = '0;
      if (pc_same) begin
         stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
      end
      // Reset PC equals HALT_ADDR, so an unarmed match is ignored.
      addr_halt   = armed_q && (pc_i == HALT_ADDR);
      // Counter value N-1 after N equal samples; fire on the sample that gets there.
      stable_halt = pc_same && (stable_d >= STABLE_HIT);
      halt_o      = 1'b0;
      if (HALT_MODE == HALT_MODE_ADDR) begin
         halt_o = addr_halt;
      end else if (HALT_MODE == HALT_MODE_STABLE) begin
         halt_o = stable_halt;
      end else begin
         halt_o = addr_halt | stable_halt;
      end
   end

   // Detector state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         armed_q   <= 1'b0;
         prev_pc_q <= '0;
         stable_q  <= '0;
      end else begin
         armed_q   <= armed_d;
         prev_pc_q <= prev_pc_d;
         stable_q  <= stable_d;
      end
   end

endmodule

// File: rtl/signature_dumper.sv
// End-of-test monitor: detects the core's halt loop, freezes the core, reads
// the DMEM signature region one word at a time through a spare read port and
// streams each word out over a valid/ready port. Gives up (and releases the
// core) if no halt is seen within TIMEOUT_CYCLES.
module signature_dumper
   import signature_dumper_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              ADDR_W         = 8,
   parameter logic [XLEN-1:0] HALT_ADDR      = '0,
   parameter int              HALT_MODE      = HALT_MODE_EITHER,
   parameter int              STABLE_CYCLES  = 16,
   parameter int              SIG_START_WORD = 192,
   parameter int              SIG_END_WORD   = 255,
   parameter int              TIMEOUT_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [XLEN-1:0]     pc_i,
   output logic                core_halt_o,
   output logic                mem_re_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   input  logic [XLEN-1:0]     mem_rdata_i,
   signature_dumper_if.master  sig,
   output logic                done_o,
   output logic                timeout_o,
   output state_e              state_o
);

   localparam logic [ADDR_W-1:0] START_IDX = ADDR_W'(SIG_START_WORD);
   localparam logic [ADDR_W-1:0] END_IDX   = ADDR_W'(SIG_END_WORD);
   localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam logic              TMO_EN    = (TIMEOUT_CYCLES != 0);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [31:0]       tmo_q, tmo_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   sig_data_q, sig_data_d;
   logic              sig_valid_q, sig_valid_d;
   logic              sig_last_q, sig_last_d;
   logic              halt;
   logic              handshake;

   signature_dumper_halt_detector #(
      .XLEN          (XLEN),
      .HALT_ADDR     (HALT_ADDR),
      .HALT_MODE     (HALT_MODE),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_halt_detector (
      .clk    (clk),
      .reset  (reset),
      .pc_i   (pc_i),
      .halt_o (halt)
   );

   assign handshake = sig_valid_q && sig.sig_ready;

   // Next-state logic: watch for halt/timeout, then READ -> WAIT -> SEND per word.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      tmo_d       = tmo_q;
      mem_addr_d  = mem_addr_q;
      sig_data_d  = sig_data_q;
      sig_valid_d = sig_valid_q;
      sig_last_d  = sig_last_q;
      unique case (state_q)
         ST_WATCH: begin
            tmo_d = tmo_q + 32'd1;
            // Halt takes priority over a timeout landing in the same cycle.
            if (halt) begin
               state_d    = ST_READ;
               mem_addr_d = index_q;
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Read data arrives one cycle after the strobe.
            sig_data_d  = mem_rdata_i;
            sig_valid_d = 1'b1;
            sig_last_d  = (index_q == END_IDX);
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (handshake) begin
               sig_valid_d = 1'b0;
               sig_last_d  = 1'b0;
               if (sig_last_q) begin
                  state_d = ST_DONE;
               end else begin
                  index_d    = index_q + 1'b1;
                  mem_addr_d = index_q + 1'b1;
                  state_d    = ST_READ;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         ST_TIMEOUT: begin
            state_d = ST_TIMEOUT;
         end
         default: begin
            state_d = ST_WATCH;
         end
      endcase
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_WATCH;
         index_q     <= START_IDX;
         tmo_q       <= '0;
         mem_addr_q  <= '0;
         sig_data_q  <= '0;
         sig_valid_q <= 1'b0;
         sig_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         tmo_q       <= tmo_d;
         mem_addr_q  <= mem_addr_d;
         sig_data_q  <= sig_data_d;
         sig_valid_q <= sig_valid_d;
         sig_last_q  <= sig_last_d;
      end
   end

   assign core_halt_o   = holds_core(state_q);
   assign mem_re_o      = (state_q == ST_READ);
   assign mem_addr_o    = mem_addr_q;
   assign done_o        = (state_q == ST_DONE);
   assign timeout_o     = (state_q == ST_TIMEOUT);
   assign state_o       = state_q;
   assign sig.sig_valid = sig_valid_q;
   assign sig.sig_data  = sig_data_q;
   assign sig.sig_last  = sig_last_q;

endmodule
